strtup_seq: RTL



---
 rtl/strtup_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/strtup_seq.sv
// Startup sequencer for the STRTUP primitive: qualifies PLL lock, then releases GSRN, IOEN
// and DONE in order while generating the divided UCLK. All outputs come straight from flops.
module strtup_seq #(
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned GSR_DELAY   = 8,
    parameter int unsigned IO_DELAY    = 8,
    parameter int unsigned UCLK_DIV    = 2,
    parameter bit          RELOCK      = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       lock_i,
    input  logic       start_i,
    output logic       uclk_o,
    output logic       gsrn_o,
    output logic       ioen_o,
    output logic       done_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLock = 3'd1,
        StGsrWait  = 3'd2,
        StIoWait   = 3'd3,
        StDone     = 3'd4
    } state_e;

    localparam logic [15:0] LockLast = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] GsrLast  = 16'(GSR_DELAY - 1);
    localparam logic [15:0] IoLast   = 16'(IO_DELAY - 1);
    localparam logic [7:0]  DivLast  = 8'(UCLK_DIV - 1);

    // Raw bits rather than the enum type so codes 5-7 stay representable and recoverable.
    logic [2:0]  state_q;
    logic [15:0] lock_cnt_q;
    logic [15:0] dly_cnt_q;
    logic [7:0]  div_q;
    logic        uclk_q;
    logic        gsrn_q;
    logic        ioen_q;
    logic        done_q;

    logic [15:0] lock_cnt_d;
    logic [15:0] dly_cnt_d;
    logic        div_run;

    always_comb begin
        lock_cnt_d = (lock_cnt_q == 16'hFFFF) ? lock_cnt_q : lock_cnt_q + 16'd1;
        dly_cnt_d  = (dly_cnt_q == 16'hFFFF) ? dly_cnt_q : dly_cnt_q + 16'd1;
        div_run    = (state_q == StWaitLock) || (state_q == StGsrWait) ||
                     (state_q == StIoWait) || (state_q == StDone);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            lock_cnt_q <= '0;
            dly_cnt_q  <= '0;
            div_q      <= '0;
            uclk_q     <= 1'b0;
            gsrn_q     <= 1'b0;
            ioen_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (div_run) begin
                if (div_q == DivLast) begin
                    div_q  <= '0;
                    uclk_q <= ~uclk_q;
                end else begin
                    div_q <= div_q + 8'd1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q    <= StWaitLock;
                        lock_cnt_q <= '0;
                    end
                end
                StWaitLock: begin
                    if (!lock_i) begin
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == LockLast) begin
                        state_q   <= StGsrWait;
                        dly_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_d;
                    end
                end
                StGsrWait: begin
                    if (!lock_i) begin
                        state_q    <= StWaitLock;
                        lock_cnt_q <= '0;
                    end else if (dly_cnt_q == GsrLast) begin
                        state_q   <= StIoWait;
                        gsrn_q    <= 1'b1;
                        dly_cnt_q <= '0;
                    end else begin
                        dly_cnt_q <= dly_cnt_d;
                    end
                end
                StIoWait: begin
                    if (!lock_i) begin
                        state_q    <= StWaitLock;
                        lock_cnt_q <= '0;
                        gsrn_q     <= 1'b0;
                    end else if (dly_cnt_q == IoLast) begin
                        state_q   <= StDone;
                        ioen_q    <= 1'b1;
                        done_q    <= 1'b1;
                        dly_cnt_q <= '0;
                    end else begin
                        dly_cnt_q <= dly_cnt_d;
                    end
                end
                StDone: begin
                    if (RELOCK && !lock_i) begin
                        state_q    <= StWaitLock;
                        lock_cnt_q <= '0;
                        gsrn_q     <= 1'b0;
                        ioen_q     <= 1'b0;
                        done_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    lock_cnt_q <= '0;
                    dly_cnt_q  <= '0;
                    div_q      <= '0;
                    uclk_q     <= 1'b0;
                    gsrn_q     <= 1'b0;
                    ioen_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign uclk_o  = uclk_q;
    assign gsrn_o  = gsrn_q;
    assign ioen_o  = ioen_q;
    assign done_o  = done_q;
    assign state_o = state_q;

endmodule
